// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station with dual-CDB wakeup and one registered issue per cycle.
// Define RS_WAKEUP_BYPASS_EN to let entries issue directly off a same-cycle CDB broadcast.
module rs_alu #(
  parameter int RS_SIZE = 16,
  parameter int OP_W = 6,
  parameter int DATA_W = 32,
  parameter int TAG_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              dsp_valid_in,
  input  logic [OP_W-1:0]   dsp_op_in,
  input  logic [DATA_W-1:0] dsp_vj_in,
  input  logic [TAG_W-1:0]  dsp_qj_in,
  input  logic              dsp_qj_busy_in,
  input  logic [DATA_W-1:0] dsp_vk_in,
  input  logic [TAG_W-1:0]  dsp_qk_in,
  input  logic              dsp_qk_busy_in,
  input  logic [DATA_W-1:0] dsp_imm_in,
  input  logic [DATA_W-1:0] dsp_pc_in,
  input  logic [TAG_W-1:0]  dsp_tag_in,
  output logic              rs_full_out,
  input  logic              cdb0_valid_in,
  input  logic [TAG_W-1:0]  cdb0_tag_in,
  input  logic [DATA_W-1:0] cdb0_data_in,
  input  logic              cdb1_valid_in,
  input  logic [TAG_W-1:0]  cdb1_tag_in,
  input  logic [DATA_W-1:0] cdb1_data_in,
  output logic              issue_valid_out,
  output logic [OP_W-1:0]   op_type_ex,
  output logic [DATA_W-1:0] data_rs1_ex,
  output logic [DATA_W-1:0] data_rs2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [TAG_W-1:0]  tag_in_rob
);
  localparam int IDX_W = $clog2(RS_SIZE);
  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic              qjb;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
    logic              qkb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  tag;
  } ent_t;
  ent_t ent_q [RS_SIZE];
  ent_t ent_d [RS_SIZE];
  logic [DATA_W:0] wj [RS_SIZE];
  logic [DATA_W:0] wk [RS_SIZE];
  logic [RS_SIZE-1:0] busy_v;
  logic [IDX_W-1:0] sel, alloc;
  logic sel_ok;
  logic vld_q, vld_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, pc_q, pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
`ifdef RS_WAKEUP_BYPASS_EN
  logic byp_ok;
  logic [IDX_W-1:0] byp;
`endif
  // {still_pending, value}; cdb0 takes precedence if both buses carry the tag
  function automatic logic [DATA_W:0] snoop(input logic b, input logic [TAG_W-1:0] q,
                                            input logic [DATA_W-1:0] v);
    return !b ? {1'b0, v} :
           (cdb0_valid_in && cdb0_tag_in == q) ? {1'b0, cdb0_data_in} :
           (cdb1_valid_in && cdb1_tag_in == q) ? {1'b0, cdb1_data_in} : {1'b1, v};
  endfunction
  always_comb begin
    sel_ok = 1'b0;
    sel = '0;
    alloc = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      busy_v[i] = ent_q[i].busy;
      wj[i] = snoop(ent_q[i].qjb, ent_q[i].qj, ent_q[i].vj);
      wk[i] = snoop(ent_q[i].qkb, ent_q[i].qk, ent_q[i].vk);
      if (ent_q[i].busy && !ent_q[i].qjb && !ent_q[i].qkb) begin
        sel_ok = 1'b1;
        sel = IDX_W'(i);
      end
      if (!ent_q[i].busy) alloc = IDX_W'(i);
    end
`ifdef RS_WAKEUP_BYPASS_EN
    byp_ok = 1'b0;
    byp = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (ent_q[i].busy && !wj[i][DATA_W] && !wk[i][DATA_W]) begin
        byp_ok = 1'b1;
        byp = IDX_W'(i);
      end
    if (!sel_ok && byp_ok) begin
      sel_ok = 1'b1;
      sel = byp;
    end
`endif
  end
  assign rs_full_out = &busy_v;
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      {ent_d[i].qjb, ent_d[i].vj} = wj[i];
      {ent_d[i].qkb, ent_d[i].vk} = wk[i];
    end
    if (sel_ok) ent_d[sel].busy = 1'b0;
    // the issuing entry is still busy here, so alloc can never collide with sel
    if (dsp_valid_in && !rs_full_out) begin
      ent_d[alloc] = '{1'b1, dsp_op_in, dsp_vj_in, dsp_qj_in, dsp_qj_busy_in, dsp_vk_in,
                       dsp_qk_in, dsp_qk_busy_in, dsp_imm_in, dsp_pc_in, dsp_tag_in};
      {ent_d[alloc].qjb, ent_d[alloc].vj} = snoop(dsp_qj_busy_in, dsp_qj_in, dsp_vj_in);
      {ent_d[alloc].qkb, ent_d[alloc].vk} = snoop(dsp_qk_busy_in, dsp_qk_in, dsp_vk_in);
    end
    if (clear_in)
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    vld_d = sel_ok && !clear_in;
    op_d = vld_d ? ent_q[sel].op : '0;
    rs1_d = vld_d ? wj[sel][DATA_W-1:0] : '0;
    rs2_d = vld_d ? wk[sel][DATA_W-1:0] : '0;
    imm_d = vld_d ? ent_q[sel].imm : '0;
    pc_d = vld_d ? ent_q[sel].pc : '0;
    tag_d = vld_d ? ent_q[sel].tag : '0;
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      ent_q <= '{default: '0};
      vld_q <= 1'b0;
      op_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      pc_q <= '0;
      tag_q <= '0;
    end else if (rdy_in) begin
      ent_q <= ent_d;
      vld_q <= vld_d;
      op_q <= op_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      imm_q <= imm_d;
      pc_q <= pc_d;
      tag_q <= tag_d;
    end
  assign issue_valid_out = vld_q;
  assign op_type_ex = op_q;
  assign data_rs1_ex = rs1_q;
  assign data_rs2_ex = rs2_q;
  assign imm_ex = imm_q;
  assign pc_ex = pc_q;
  assign tag_in_rob = tag_q;
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: randomized and directed checks of rs_alu against a slot-array reference model.
module tb_rs_alu;
  localparam int N = 16, OW = 6, DW = 32, TW = 4;
  logic clk_in = 1'b0, rst_in, rdy_in, clear_in, dsp_valid_in;
  logic [OW-1:0] dsp_op_in;
  logic [DW-1:0] dsp_vj_in, dsp_vk_in, dsp_imm_in, dsp_pc_in, cdb0_data_in, cdb1_data_in;
  logic [TW-1:0] dsp_qj_in, dsp_qk_in, dsp_tag_in, cdb0_tag_in, cdb1_tag_in;
  logic dsp_qj_busy_in, dsp_qk_busy_in, cdb0_valid_in, cdb1_valid_in;
  logic rs_full_out, issue_valid_out;
  logic [OW-1:0] op_type_ex;
  logic [DW-1:0] data_rs1_ex, data_rs2_ex, imm_ex, pc_ex;
  logic [TW-1:0] tag_in_rob;
  always #5 clk_in = ~clk_in;
  rs_alu dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dsp_valid_in(dsp_valid_in), .dsp_op_in(dsp_op_in), .dsp_vj_in(dsp_vj_in),
    .dsp_qj_in(dsp_qj_in), .dsp_qj_busy_in(dsp_qj_busy_in), .dsp_vk_in(dsp_vk_in),
    .dsp_qk_in(dsp_qk_in), .dsp_qk_busy_in(dsp_qk_busy_in), .dsp_imm_in(dsp_imm_in),
    .dsp_pc_in(dsp_pc_in), .dsp_tag_in(dsp_tag_in), .rs_full_out(rs_full_out),
    .cdb0_valid_in(cdb0_valid_in), .cdb0_tag_in(cdb0_tag_in), .cdb0_data_in(cdb0_data_in),
    .cdb1_valid_in(cdb1_valid_in), .cdb1_tag_in(cdb1_tag_in), .cdb1_data_in(cdb1_data_in),
    .issue_valid_out(issue_valid_out), .op_type_ex(op_type_ex), .data_rs1_ex(data_rs1_ex),
    .data_rs2_ex(data_rs2_ex), .imm_ex(imm_ex), .pc_ex(pc_ex), .tag_in_rob(tag_in_rob)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic m_busy [N], m_qjb [N], m_qkb [N];
  logic [OW-1:0] m_op [N];
  logic [DW-1:0] m_vj [N], m_vk [N], m_imm [N], m_pc [N];
  logic [TW-1:0] m_qj [N], m_qk [N], m_tag [N];
  logic e_vld;
  logic [OW-1:0] e_op;
  logic [DW-1:0] e_rs1, e_rs2, e_imm, e_pc;
  logic [TW-1:0] e_tag;
  function automatic logic [DW:0] res(input logic b, input logic [TW-1:0] q, input logic [DW-1:0] v);
    if (b && cdb0_valid_in && cdb0_tag_in == q) return {1'b0, cdb0_data_in};
    if (b && cdb1_valid_in && cdb1_tag_in == q) return {1'b0, cdb1_data_in};
    return {b, v};
  endfunction
  function automatic logic m_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic out_zero();
    e_vld = 0; e_op = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_pc = '0; e_tag = '0;
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    out_zero();
  endtask
  task automatic model_edge();
    int s;
    logic full;
    logic [DW:0] a, b;
    if (!rdy_in) return;
    out_zero();
    if (clear_in) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      return;
    end
    full = m_full();
    s = -1;
    for (int i = 0; i < N; i++)
      if (s < 0 && m_busy[i] && !m_qjb[i] && !m_qkb[i]) s = i;
`ifdef RS_WAKEUP_BYPASS_EN
    for (int i = 0; i < N; i++) begin
      a = res(m_qjb[i], m_qj[i], m_vj[i]);
      b = res(m_qkb[i], m_qk[i], m_vk[i]);
      if (s < 0 && m_busy[i] && !a[DW] && !b[DW]) s = i;
    end
`endif
    if (s >= 0) begin
      a = res(m_qjb[s], m_qj[s], m_vj[s]);
      b = res(m_qkb[s], m_qk[s], m_vk[s]);
      e_vld = 1; e_op = m_op[s]; e_rs1 = a[DW-1:0]; e_rs2 = b[DW-1:0];
      e_imm = m_imm[s]; e_pc = m_pc[s]; e_tag = m_tag[s];
    end
    for (int i = 0; i < N; i++)
      if (m_busy[i]) begin
        {m_qjb[i], m_vj[i]} = res(m_qjb[i], m_qj[i], m_vj[i]);
        {m_qkb[i], m_vk[i]} = res(m_qkb[i], m_qk[i], m_vk[i]);
      end
    if (dsp_valid_in && !full)
      for (int i = 0; i < N; i++)
        if (!m_busy[i] && i != s) begin
          m_busy[i] = 1; m_op[i] = dsp_op_in; m_imm[i] = dsp_imm_in; m_pc[i] = dsp_pc_in;
          m_tag[i] = dsp_tag_in; m_qj[i] = dsp_qj_in; m_qk[i] = dsp_qk_in;
          {m_qjb[i], m_vj[i]} = res(dsp_qj_busy_in, dsp_qj_in, dsp_vj_in);
          {m_qkb[i], m_vk[i]} = res(dsp_qk_busy_in, dsp_qk_in, dsp_vk_in);
          break;
        end
    if (s >= 0) m_busy[s] = 0;
  endtask
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    chk("vld", issue_valid_out, e_vld);
    chk("op", op_type_ex, e_op);
    chk("rs1", data_rs1_ex, e_rs1);
    chk("rs2", data_rs2_ex, e_rs2);
    chk("imm", imm_ex, e_imm);
    chk("pc", pc_ex, e_pc);
    chk("tag", tag_in_rob, e_tag);
    chk("full", rs_full_out, m_full());
  endtask
  task automatic idle();
    dsp_valid_in = 0; cdb0_valid_in = 0; cdb1_valid_in = 0; clear_in = 0;
  endtask
  task automatic dsp(input logic [OW-1:0] op, input logic [DW-1:0] vj, input logic qjb,
                     input logic [TW-1:0] qj, input logic [DW-1:0] vk, input logic qkb,
                     input logic [TW-1:0] qk, input logic [TW-1:0] tag);
    dsp_valid_in = 1; dsp_op_in = op; dsp_vj_in = vj; dsp_qj_busy_in = qjb; dsp_qj_in = qj;
    dsp_vk_in = vk; dsp_qk_busy_in = qkb; dsp_qk_in = qk; dsp_tag_in = tag;
    dsp_imm_in = $urandom; dsp_pc_in = $urandom;
  endtask
  task automatic async_reset(input string tag);
    #2 rst_in = 1;
    #1;
    chk({tag, "_vld"}, issue_valid_out, 0);
    chk({tag, "_op"}, op_type_ex, 0);
    chk({tag, "_rs1"}, data_rs1_ex, 0);
    chk({tag, "_full"}, rs_full_out, 0);
    model_reset();
    @(negedge clk_in) rst_in = 0;
  endtask
  int n_iss, n_bad;
  initial begin
    rst_in = 1; rdy_in = 1; idle();
    {dsp_op_in, dsp_vj_in, dsp_vk_in, dsp_imm_in, dsp_pc_in} = '0;
    {dsp_qj_in, dsp_qk_in, dsp_tag_in, dsp_qj_busy_in, dsp_qk_busy_in} = '0;
    {cdb0_tag_in, cdb0_data_in, cdb1_tag_in, cdb1_data_in} = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_vld", issue_valid_out, 0);
    chk("rst_op", op_type_ex, 0);
    chk("rst_full", rs_full_out, 0);
    @(negedge clk_in) rst_in = 0;
    // plain ready op: visible two edges after dispatch
    dsp(6'd1, 32'd5, 0, 0, 32'd7, 0, 0, 4'd3);
    step(); idle();
    chk("t1_early", issue_valid_out, 0);
    step();
    chk("t1_vld", issue_valid_out, 1);
    chk("t1_op", op_type_ex, 1);
    chk("t1_rs1", data_rs1_ex, 5);
    chk("t1_rs2", data_rs2_ex, 7);
    chk("t1_tag", tag_in_rob, 3);
    step();
    chk("t1_after", issue_valid_out, 0);
    // same-cycle cdb1 capture during dispatch
    dsp(6'd2, 32'd1, 0, 0, 32'd0, 1, 4'd9, 4'd4);
    cdb1_valid_in = 1; cdb1_tag_in = 4'd9; cdb1_data_in = 32'hABCD;
    step(); idle(); step();
    chk("t3_rs2", data_rs2_ex, 32'hABCD);
    step();
    // fill all entries waiting on tag 1
    for (int i = 0; i < N; i++) begin
      dsp(OW'(i + 1), $urandom, 1, 4'd1, $urandom, 0, 0, TW'(i));
      step();
    end
    idle();
    chk("t4_full", rs_full_out, 1);
    dsp(6'd63, 32'd0, 0, 0, 32'd0, 0, 0, 4'd15);
    step(); idle();
    cdb0_valid_in = 1; cdb0_tag_in = 4'd1; cdb0_data_in = 32'h55;
    step(); idle();
    n_iss = 0; n_bad = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (issue_valid_out) n_iss++;
      if (op_type_ex == 6'd63) n_bad++;
    end
    chk("t4_issues", n_iss, 16);
    chk("t4_dropped", n_bad, 0);
    // async reset while an op is on the issue outputs
    dsp(6'd5, 32'd9, 0, 0, 32'd8, 0, 0, 4'd2);
    step(); idle(); step();
    chk("t6_pre", issue_valid_out, 1);
    async_reset("t6");
    step();
    chk("t6_empty", rs_full_out, 0);
    for (int c = 0; c < 1500; c++) begin
      rdy_in = $urandom_range(9) != 0;
      clear_in = $urandom_range(49) == 0;
      if ($urandom_range(9) < 6)
        dsp(OW'($urandom_range(63, 1)), $urandom, 1'($urandom_range(1)), TW'($urandom_range(3)),
            $urandom, 1'($urandom_range(1)), TW'($urandom_range(3)), TW'($urandom));
      else dsp_valid_in = 0;
      cdb0_valid_in = $urandom_range(2) == 0; cdb0_tag_in = TW'($urandom_range(3));
      cdb0_data_in = $urandom;
      cdb1_valid_in = $urandom_range(2) == 0; cdb1_tag_in = TW'($urandom_range(3));
      cdb1_data_in = $urandom;
      if ($urandom_range(9) == 0) cdb1_tag_in = cdb0_tag_in;
      step();
      if (c == 700) async_reset("rr");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- ALU reservation station of the Tomasulo core.
- Sits between dispatch and the combinational ALU execute stage. Buffers up to RS_SIZE ALU/branch/jump ops and snoops two CDBs to wake up pending operands.
- Issues at most one ready op per cycle on registered outputs that drive the execute-stage inputs directly: op type, rs1/rs2 data, imm, pc, ROB tag.

Parameters:
RS_SIZE, 16, number of entries (power of two)
OP_W, 6, op-type code width; code 0 = NOP
DATA_W, 32, operand/imm/pc width
TAG_W, 4, ROB tag width

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global ready; low = freeze all state
clear_in  in  1  flush on misprediction, synchronous
dsp_valid_in  in  1  dispatch request this cycle
dsp_op_in  in  OP_W  op type
dsp_vj_in  in  DATA_W  rs1 value (valid when dsp_qj_busy_in=0)
dsp_qj_in  in  TAG_W  rs1 producer ROB tag
dsp_qj_busy_in  in  1  rs1 pending
dsp_vk_in  in  DATA_W  rs2 value / shamt source
dsp_qk_in  in  TAG_W  rs2 producer ROB tag
dsp_qk_busy_in  in  1  rs2 pending
dsp_imm_in  in  DATA_W  immediate
dsp_pc_in  in  DATA_W  instruction pc
dsp_tag_in  in  TAG_W  destination ROB tag
rs_full_out  out  1  no free entry
cdb0_valid_in, cdb0_tag_in, cdb0_data_in  in  1/TAG_W/DATA_W  ALU result broadcast
cdb1_valid_in, cdb1_tag_in, cdb1_data_in  in  1/TAG_W/DATA_W  load/store result broadcast
issue_valid_out  out  1  issue slot occupied this cycle
op_type_ex  out  OP_W  to execute; 0 when not issuing
data_rs1_ex  out  DATA_W  to execute
data_rs2_ex  out  DATA_W  to execute
imm_ex  out  DATA_W  to execute
pc_ex  out  DATA_W  to execute
tag_in_rob  out  TAG_W  to execute

Behaviour:
- Reset: asynchronous on rst_in high. All entries invalid. All outputs 0; rs_full_out=0.
- rdy_in low: no state changes and no register updates. Outputs hold, and the ROB stalls with them.
- Entry fields: busy, op, vj, qj, qj_busy, vk, qk, qk_busy, imm, pc, tag. An entry is ready when busy && !qj_busy && !qk_busy.
- Allocation:
  - When dsp_valid_in && !rs_full_out, write the lowest-index free entry at the clock edge.
  - Same-cycle CDB match on dsp_qj_in/dsp_qk_in (busy set): capture the CDB data and clear busy in the written entry.
- Full:
  - rs_full_out = all RS_SIZE entries busy, computed combinationally from registered state.
  - Dispatch while full is ignored, even if an issue frees an entry that same edge.
- Wakeup:
  - Each cycle, every busy entry compares qj/qk against both CDBs. On a match with the busy bit set, it latches the data and clears the busy bit.
  - If both CDBs match the same tag, cdb0 wins. That case is illegal in practice, but the outcome is fixed.
- Selection and issue:
  - Each cycle select the lowest-index ready entry, using registered readiness.
  - At the edge, copy it into the output registers, set issue_valid_out=1, and free the entry.
  - With nothing ready: issue_valid_out=0, op_type_ex=0; the other outputs are zeroed.
- Latency:
  - Dispatch with ready operands in cycle N -> outputs valid in cycle N+2.
  - Wakeup in cycle N -> selectable in N+1 -> outputs valid in N+2.
- clear_in:
  - Highest priority after reset. All entries invalid; issue outputs zeroed at the edge.
  - A dispatch in the same cycle is dropped.
- Simultaneous issue and dispatch to different entries are both honoured. The allocator never picks the entry being issued that cycle.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined:
  - Selection also considers entries whose only outstanding operand(s) match a CDB this cycle.
  - The CDB data is forwarded straight into data_rs1_ex/data_rs2_ex, so wakeup in cycle N gives outputs valid in N+1.
  - A fully ready entry keeps priority over a bypass candidate of lower index. Ordering: ready entries first, lowest index within each class.
- Undefined: wakeup-to-issue takes two cycles, as specified above.

Test Plan:
1. Dispatch op ADD, vj=5, vk=7, no busy, tag=3, in cycle 0 -> cycle 2 shows issue_valid_out=1, op_type_ex=ADD, data_rs1_ex=5, data_rs2_ex=7, tag_in_rob=3; cycle 3 shows issue_valid_out=0, op_type_ex=0.
2. Dispatch with qj_busy=1, qj=2 -> no issue. In cycle 5, cdb0 tag=2 data=0x100 -> data_rs1_ex=0x100 valid in cycle 7, or cycle 6 with the bypass macro defined.
3. Dispatch with qk_busy=1, qk=9 in the same cycle that cdb1 broadcasts tag=9 data=0xABCD -> entry is written ready; issues with data_rs2_ex=0xABCD two cycles later.
4. Dispatch 16 ops all waiting on tag 1 -> rs_full_out=1; a 17th dispatch (tag 15) never issues. Broadcast tag 1 -> entries issue one per cycle in index order over 16 consecutive cycles, and rs_full_out drops after the first issue.
5. Load 3 ready ops, assert clear_in for one cycle while dispatching a 4th -> at most the one issue already registered appears; afterwards issue_valid_out stays 0 and rs_full_out=0.
6. Assert rst_in asynchronously mid-cycle while issuing -> outputs go to 0 immediately without a clock edge, and no entries remain after release.
